// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer: controller state,
// the per-stage enable/flush bundle, and the named control patterns that the
// sequencer chooses between each cycle.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned DRAIN_DEPTH_DEF = 3;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned WAIT_W          = 16;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HALT_DRAIN = 2'd1,
    HALTED     = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic mem_wb_en;
  } stage_ctrl_t;

  // Everything held, nothing flushed: reset, freeze and halted.
  localparam stage_ctrl_t CTRL_HOLD = '0;

  // Normal advance of every stage.
  localparam stage_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b0, ex_mem_en: 1'b1, ex_mem_flush: 1'b0, mem_wb_en: 1'b1};

  // PC takes the branch target; the two wrong-path instructions become bubbles.
  localparam stage_ctrl_t CTRL_REDIRECT = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, ex_mem_flush: 1'b0, mem_wb_en: 1'b1};

  // PC stops, front end fills with bubbles, older instructions retire.
  localparam stage_ctrl_t CTRL_DRAIN = '{
    pc_en: 1'b0, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, ex_mem_flush: 1'b0, mem_wb_en: 1'b1};

  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  localparam stage_ctrl_t CTRL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, ex_mem_flush: 1'b0, mem_wb_en: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detector: the instruction in ID reads a register that the
// load currently in EX will write. x0 is never a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             lu
);

  // Pure combinational compare of ID sources against the EX load destination.
  assign lu = ex_memread && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-stage enable/flush for PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB covering load-use stall, EX redirect, data-memory wait freeze, halt
// drain and a data-memory timeout that stops the machine with a sticky error.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/flush/wait
// performance counters; without it those ports are tied to zero.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned DRAIN_DEPTH = DRAIN_DEPTH_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_halt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_DEPTH + 1);

  pipe_state_e        state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic [WAIT_W-1:0]  wait_ctr;
  logic               lu;
  logic               freeze;
  logic               timeout;
  logic               do_redirect;
  logic               do_lu;
  stage_ctrl_t        ctrl;
  stage_ctrl_t        ctrl_out;

  load_use_detect u_load_use_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .lu         (lu)
  );

  assign freeze  = mem_req && !dmem_ready && (state != HALTED);
  assign timeout = freeze && (wait_ctr == WAIT_W'(MEM_TIMEOUT - 1));

  // Next-state and stage-control selection in priority order.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    ctrl        = CTRL_HOLD;
    state_nxt   = state;
    drain_nxt   = drain_cnt;
    do_redirect = 1'b0;
    do_lu       = 1'b0;
    unique case (state)
      RUN: begin
        if (freeze) begin
          ctrl = CTRL_HOLD;
        end else if (ex_redirect) begin
          ctrl        = CTRL_REDIRECT;
          do_redirect = 1'b1;
        end else if (id_halt) begin
          ctrl      = CTRL_DRAIN;
          state_nxt = HALT_DRAIN;
          drain_nxt = DRAIN_W'(DRAIN_DEPTH);
        end else if (lu) begin
          ctrl  = CTRL_LOAD_USE;
          do_lu = 1'b1;
        end else begin
          ctrl = CTRL_RUN;
        end
      end
      HALT_DRAIN: begin
        if (!freeze) begin
          ctrl      = CTRL_DRAIN;
          drain_nxt = drain_cnt - DRAIN_W'(1);
          if (drain_cnt == DRAIN_W'(1)) state_nxt = HALTED;
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
    // A stuck memory access abandons whatever was in flight.
    if (timeout) state_nxt = HALTED;
  end

  // Reset forces every stage to hold regardless of the state decode.
  always_comb begin
    ctrl_out = reset ? ctrl : CTRL_HOLD;
  end

  assign pc_en        = ctrl_out.pc_en;
  assign if_id_en     = ctrl_out.if_id_en;
  assign if_id_flush  = ctrl_out.if_id_flush;
  assign id_ex_en     = ctrl_out.id_ex_en;
  assign id_ex_flush  = ctrl_out.id_ex_flush;
  assign ex_mem_en    = ctrl_out.ex_mem_en;
  assign ex_mem_flush = ctrl_out.ex_mem_flush;
  assign mem_wb_en    = ctrl_out.mem_wb_en;
  assign halted       = (state == HALTED);

  // State, drain countdown, consecutive-wait counter and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      drain_cnt <= '0;
      wait_ctr  <= '0;
      mem_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values and simulation matches hardware.
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      wait_ctr  <= freeze ? wait_ctr + WAIT_W'(1) : '0;
      if (timeout) mem_err <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q, wait_q;

  // Saturating event counters; none of their events can occur while halted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      if (do_lu && (stall_q != '1))       stall_q <= stall_q + CNT_W'(1);
      if (do_redirect && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      if (freeze && (wait_q != '1))       wait_q  <= wait_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign wait_cnt  = wait_q;
`else
  logic unused_perf;
  assign unused_perf = do_lu ^ do_redirect;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
  assign wait_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// randomized stimulus, every cycle compared against a behavioural model.
module tb_pipeline_ctrl;

  localparam int TO    = 8;
  localparam int DEPTH = 3;
  localparam int CW    = 32;

  // Expected control vectors, bit order:
  // pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en
  localparam logic [7:0] E_HOLD  = 8'b0000_0000;
  localparam logic [7:0] E_RUN   = 8'b1101_0101;
  localparam logic [7:0] E_REDIR = 8'b1111_1101;
  localparam logic [7:0] E_DRAIN = 8'b0111_1101;
  localparam logic [7:0] E_LU    = 8'b0001_1101;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, id_halt, ex_memread, ex_redirect;
  logic          mem_req, dmem_ready;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic          ex_mem_en, ex_mem_flush, mem_wb_en, halted, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit      m_halted, m_err;
  int      m_drain_left, m_wait_run;
  longint  m_stall, m_flush, m_waits;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .DRAIN_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk (clk), .reset (reset),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2),
    .id_halt (id_halt), .ex_memread (ex_memread), .ex_rd (ex_rd), .ex_redirect (ex_redirect),
    .mem_req (mem_req), .dmem_ready (dmem_ready),
    .pc_en (pc_en), .if_id_en (if_id_en), .if_id_flush (if_id_flush),
    .id_ex_en (id_ex_en), .id_ex_flush (id_ex_flush), .ex_mem_en (ex_mem_en),
    .ex_mem_flush (ex_mem_flush), .mem_wb_en (mem_wb_en),
    .halted (halted), .mem_err (mem_err),
    .stall_cnt (stall_cnt), .flush_cnt (flush_cnt), .wait_cnt (wait_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_vec();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en};
  endfunction

  function automatic bit m_load_use();
    return ex_memread && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit m_frozen();
    return mem_req && !dmem_ready && !m_halted;
  endfunction

  function automatic logic [7:0] m_ctrl();
    if (!reset || m_halted || m_frozen()) return E_HOLD;
    if (m_drain_left > 0) return E_DRAIN;
    if (ex_redirect)      return E_REDIR;
    if (id_halt)          return E_DRAIN;
    if (m_load_use())     return E_LU;
    return E_RUN;
  endfunction

  function automatic logic [63:0] m_cnt(input longint v);
`ifdef PIPE_PERF_CNT_EN
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(v);
`else
    return (v < 0) ? 64'(v) : 64'd0;
`endif
  endfunction

  task automatic model_reset();
    m_halted = 0; m_err = 0; m_drain_left = 0; m_wait_run = 0;
    m_stall = 0; m_flush = 0; m_waits = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    bit frz;
    if (!reset) return;
    frz = m_frozen();
    if (!frz && !m_halted) begin
      if (m_drain_left > 0) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end else if (ex_redirect) m_flush++;
      else if (id_halt)         m_drain_left = DEPTH;
      else if (m_load_use())    m_stall++;
    end
    if (frz) begin
      m_waits++;
      m_wait_run++;
      if (m_wait_run == TO) begin
        m_err = 1; m_halted = 1; m_drain_left = 0;
      end
    end else begin
      m_wait_run = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ":ctrl"},   ctrl_vec(), m_ctrl());
    check({tag, ":halted"}, halted,     m_halted);
    check({tag, ":mem_err"}, mem_err,   m_err);
    check({tag, ":stall"},  stall_cnt,  m_cnt(m_stall));
    check({tag, ":flush"},  flush_cnt,  m_cnt(m_flush));
    check({tag, ":wait"},   wait_cnt,   m_cnt(m_waits));
  endtask

  // Inputs are already applied; compare, then clock once.
  task automatic step(input string tag);
    #1;
    compare_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_halt = 0;
    ex_memread = 0; ex_rd = 0; ex_redirect = 0; mem_req = 0; dmem_ready = 1;
  endtask

  task automatic apply_reset();
    ex_redirect = 1'b1;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all("rst");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    idle();
    reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #2;
    apply_reset();

    // Load-use stall and its x0 exemption
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1 check("lu_pattern", ctrl_vec(), E_LU);
    step("lu");
    ex_memread = 0;
    #1 check("lu_one_bubble", ctrl_vec(), E_RUN);
    step("lu_after");
    ex_memread = 1; ex_rd = 0; id_rs1 = 0;
    #1 check("lu_x0", ctrl_vec(), E_RUN);
    step("lu_x0");
    idle();

    // Redirect outranks halt and load-use
    ex_redirect = 1; id_halt = 1; ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    #1 check("redir_prio", ctrl_vec(), E_REDIR);
    step("redir_prio");
    idle();
    #1 check("redir_stays_run", ctrl_vec(), E_RUN);
    step("redir_after");

    // Four-cycle freeze holds a pending redirect
    mem_req = 1; dmem_ready = 0; ex_redirect = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check("freeze_hold", ctrl_vec(), E_HOLD);
      step("freeze");
    end
    dmem_ready = 1;
    #1 check("freeze_release", ctrl_vec(), E_REDIR);
    step("freeze_release");
    idle();

    // Halt drain: three cycles then halted
    id_halt = 1;
    step("halt");
    idle();
    for (int i = 0; i < 3; i++) begin
      #1 check("drain_ctrl", ctrl_vec(), E_DRAIN);
      step("drain");
    end
    #1 check("halted_flag", halted, 1'b1);
    check("halted_ctrl", ctrl_vec(), E_HOLD);
    mem_req = 1; dmem_ready = 0;
    step("halted_ignore_mem");
    apply_reset();

    // Halt drain stretched by two frozen cycles
    id_halt = 1;
    step("halt2");
    idle();
    step("drain2_a");
    mem_req = 1; dmem_ready = 0;
    step("drain2_frz");
    step("drain2_frz");
    idle();
    step("drain2_b");
    #1 check("drain2_not_yet", halted, 1'b0);
    step("drain2_c");
    #1 check("drain2_halted", halted, 1'b1);
    apply_reset();

    // Memory timeout
    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      if (i == TO - 1) check("to_not_yet", mem_err, 1'b0);
      step("to_wait");
    end
    #1 check("to_mem_err", mem_err, 1'b1);
    check("to_halted", halted, 1'b1);
    check("to_ctrl", ctrl_vec(), E_HOLD);
    step("to_after");
    apply_reset();
    #1 check("to_clear_err", mem_err, 1'b0);
    check("to_clear_halted", halted, 1'b0);

    // Counter scenario: 2 load-use, 3 redirect, 4 freeze cycles
    ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    step("cnt_lu"); step("cnt_lu");
    idle();
    ex_redirect = 1;
    step("cnt_rd"); step("cnt_rd"); step("cnt_rd");
    idle();
    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) step("cnt_frz");
    idle();
    #1;
`ifdef PIPE_PERF_CNT_EN
    check("cnt_stall", stall_cnt, 2);
    check("cnt_flush", flush_cnt, 3);
    check("cnt_wait",  wait_cnt,  4);
`else
    check("cnt_stall", stall_cnt, 0);
    check("cnt_flush", flush_cnt, 0);
    check("cnt_wait",  wait_cnt,  0);
`endif
    step("cnt_done");

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0 || (m_halted && $urandom_range(0, 14) == 0)) begin
        apply_reset();
      end else begin
        id_rs1      = 5'($urandom_range(0, 3));
        id_rs2      = 5'($urandom_range(0, 3));
        ex_rd       = 5'($urandom_range(0, 3));
        id_use_rs1  = 1'($urandom_range(0, 1));
        id_use_rs2  = 1'($urandom_range(0, 1));
        ex_memread  = 1'($urandom_range(0, 1));
        id_halt     = ($urandom_range(0, 29) == 0);
        ex_redirect = ($urandom_range(0, 5) == 0);
        mem_req     = 1'($urandom_range(0, 1));
        dmem_ready  = ($urandom_range(0, 2) != 0);
        step("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
